fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of decode.
- Holds the PC and issues word-aligned requests to instruction memory over a req/ack handshake.
- Presents one instruction per cycle to decode through a registered IF/ID slot with a valid flag.
- Handles decode stall, redirects (taken branch/jump from execute) and HALT detection.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, instruction driven on instr when the slot is empty.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- stall  in  1  decode cannot accept; IF/ID slot holds.
- redirect  in  1  replace PC with redirect_pc; squash younger fetches.
- redirect_pc  in  16  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address (current PC).
- imem_ack  in  1  memory returns imem_rdata this cycle; may arrive the same cycle as req.
- imem_rdata  in  16  fetched instruction.
- instr  out  16  IF/ID instruction to decode.
- pc_inc  out  16  address of instr + 2.
- instr_valid  out  1  instr/pc_inc valid.
- halted  out  1  HALT (opcode 5'b00000) delivered; fetching stopped.
- err  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (async, rst_n=0) values:
  - pc=RESET_PC, instr=NOP_INSTR, pc_inc=16'h0000.
  - instr_valid=0, halted=0, err=0, imem_req=0.
  - Skid buffer empty; state=FETCH.
  - The first imem_req is issued in the first cycle after rst_n rises.
- Reset mid-transaction: any outstanding request is abandoned; memory must tolerate this.
- State FETCH:
  - imem_req=1 and imem_addr=pc whenever the skid buffer is empty.
  - req, once raised, is held with a stable addr until ack (redirect excepted, see DRAIN).
- On ack with no redirect:
  - pc<=pc+2, mod 2^16, so FFFE wraps to 0000.
  - If the slot is free (instr_valid=0 or stall=0): instr<=imem_rdata, pc_inc<=pc+2, instr_valid<=1.
  - Otherwise the data goes to the one-entry skid buffer; no new req while the skid is full.
- Slot consumption:
  - When stall=0 and the skid is full, the skid moves into the slot next cycle.
  - stall=0 with no new data: instr_valid<=0, instr<=NOP_INSTR.
- Latency and throughput: a single-cycle-ack memory gives 1 instruction/cycle; instr_valid rises 1 cycle after ack.
- Redirect has highest priority; in the same cycle:
  - instr_valid<=0, skid cleared.
  - pc<={redirect_pc[15:1],1'b0}.
  - If redirect_pc[0]=1, err<=1 (sticky until reset).
  - If a request is outstanding and not acked this cycle: state DRAIN. req stays high with the old addr until ack, that data is discarded, then FETCH resumes at the new pc.
  - Ack coincident with redirect: the data is discarded and the next req uses the new pc the following cycle.
  - Redirect coincident with stall: redirect wins and the slot is squashed.
- HALT:
  - When an instruction with [15:11]=5'b00000 is written into the slot: state HALTED, halted<=1, no further req.
  - The HALT instruction itself is still presented with instr_valid=1 until consumed.
- HALTED exit:
  - A redirect while HALTED clears halted, returns to FETCH at the target and squashes the speculative HALT.
  - Otherwise HALTED persists until reset.
- Outputs are driven only from registers; no combinational path from stall/ack to instr.

Test Plan:
- Reset release with RESET_PC=0, memory acking same cycle holding 0xC001,0xC102,0xC203 -> addrs 0000,0002,0004 on consecutive cycles; instr_valid from cycle 2; pc_inc 0002,0004,0006.
- stall held 3 cycles while memory acks -> slot holds, one word captured in the skid, req drops; on release the words come out in order with no loss or duplication.
- Redirect to 0x0040 while a 3-cycle-latency request to 0x0010 is outstanding -> 0x0010 data discarded; next delivered instr comes from 0x0040 with pc_inc=0x0042; instr_valid low in between.
- Fetch at pc=FFFE -> next imem_addr 0000; pc_inc=0000 for that instruction.
- Memory returns 0x0000 -> instr_valid=1 with instr=0000, halted=1, imem_req stays 0 for 10 cycles; then redirect to 0x0100 -> halted=0 and fetch resumes at 0x0100.
- Redirect to 0x0023 -> err=1 and persists; fetch proceeds at 0x0022; rst_n low mid-wait -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: decode-side slot/control signals plus the instruction-memory req/ack channel.
// master is the fetch stage; slave is decode/memory/execute as seen from outside.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        instr_valid;
    logic        halted;
    logic        err;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, pc_inc, instr_valid, halted, err
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, pc_inc, instr_valid, halted, err
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack, registered IF/ID slot; instr_valid one cycle after ack.
// Decode stall holds the slot and parks one word in a skid buffer, which gates further requests.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
    } slot_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] tgt_q, tgt_d;
    slot_t       slot_q, slot_d;
    logic        slot_vld_q, slot_vld_d;
    slot_t       skid_dat_q, skid_dat_d;
    logic        skid_vld_q, skid_vld_d;
    logic        req_q, req_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic        ack;
    logic        slot_free;
    logic        slot_wr;
    logic [15:0] pc_next;
    logic [15:0] redir_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            slot_q     <= '{instr: NOP_INSTR, pc_inc: 16'h0000};
            slot_vld_q <= 1'b0;
            skid_dat_q <= '0;
            skid_vld_q <= 1'b0;
            req_q      <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            skid_dat_q <= skid_dat_d;
            skid_vld_q <= skid_vld_d;
            req_q      <= req_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        slot_d     = slot_q;
        slot_vld_d = slot_vld_q;
        skid_dat_d = skid_dat_q;
        skid_vld_d = skid_vld_q;
        halted_d   = halted_q;
        err_d      = err_q;
        slot_wr    = 1'b0;
        ack        = req_q && bus.imem_ack;
        slot_free  = !slot_vld_q || !bus.stall;
        pc_next    = pc_q + 16'd2;
        redir_pc   = {bus.redirect_pc[15:1], 1'b0};

        if (bus.redirect) begin
            slot_vld_d   = 1'b0;
            slot_d.instr = NOP_INSTR;
            skid_vld_d   = 1'b0;
            halted_d     = 1'b0;
            if (bus.redirect_pc[0])
                err_d = 1'b1;
            // An unacked request must still complete; park the target until it does.
            if (req_q && !bus.imem_ack) begin
                state_d = DRAIN;
                tgt_d   = redir_pc;
            end else begin
                state_d = FETCH;
                pc_d    = redir_pc;
            end
        end else if (state_q == DRAIN) begin
            if (ack) begin
                state_d = FETCH;
                pc_d    = tgt_q;
            end
        end else begin
            if (ack) begin
                pc_d = pc_next;
                if (slot_free) begin
                    slot_d     = '{instr: bus.imem_rdata, pc_inc: pc_next};
                    slot_vld_d = 1'b1;
                    slot_wr    = 1'b1;
                end else begin
                    skid_dat_d = '{instr: bus.imem_rdata, pc_inc: pc_next};
                    skid_vld_d = 1'b1;
                end
            end else if (skid_vld_q && !bus.stall) begin
                slot_d     = skid_dat_q;
                slot_vld_d = 1'b1;
                skid_vld_d = 1'b0;
                slot_wr    = 1'b1;
            end else if (!bus.stall) begin
                slot_vld_d   = 1'b0;
                slot_d.instr = NOP_INSTR;
            end

            if (slot_wr && (slot_d.instr[15:11] == 5'b00000)) begin
                state_d  = HALTED;
                halted_d = 1'b1;
            end
        end

        req_d = (state_d == DRAIN) || ((state_d == FETCH) && !skid_vld_d);
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = slot_q.instr;
    assign bus.pc_inc      = slot_q.pc_inc;
    assign bus.instr_valid = slot_vld_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a configurable-latency instruction memory.
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   lat;
    int   wcnt;
    logic [15:0] mem [0:32767];

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
    assign bus.imem_rdata = mem[bus.imem_addr[15:1]];

    always @(posedge clk) begin
        if (!rst_n || !bus.imem_req || bus.imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000; lat = 0;
        repeat (3) step();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr got %h want 0000", bus.imem_addr); end
        n_cmp++; if (bus.instr !== 16'h0800) begin n_fail++; $display("FAIL rst_instr got %h want 0800", bus.instr); end
        n_cmp++; if (bus.pc_inc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc_inc got %h want 0000", bus.pc_inc); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.halted !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b want 00", bus.halted, bus.err); end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL stream_req0 got %b/%h want 1/0000", bus.imem_req, bus.imem_addr); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid0 got %b want 0", bus.instr_valid); end
        step();
        n_cmp++; if (bus.imem_addr !== 16'h0002) begin n_fail++; $display("FAIL stream_addr1 got %h want 0002", bus.imem_addr); end
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hC001 || bus.pc_inc !== 16'h0002) begin n_fail++; $display("FAIL stream_i0 got %b/%h/%h want 1/c001/0002", bus.instr_valid, bus.instr, bus.pc_inc); end
        step();
        n_cmp++; if (bus.imem_addr !== 16'h0004) begin n_fail++; $display("FAIL stream_addr2 got %h want 0004", bus.imem_addr); end
        n_cmp++; if (bus.instr !== 16'hC102 || bus.pc_inc !== 16'h0004) begin n_fail++; $display("FAIL stream_i1 got %h/%h want c102/0004", bus.instr, bus.pc_inc); end
        step();
        n_cmp++; if (bus.instr !== 16'hC203 || bus.pc_inc !== 16'h0006) begin n_fail++; $display("FAIL stream_i2 got %h/%h want c203/0006", bus.instr, bus.pc_inc); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (bus.instr !== 16'hC203 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d got %h/%b want c203/1", c, bus.instr, bus.instr_valid); end
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d got %b want 0", c, bus.imem_req); end
        end
        bus.stall = 1'b0;
        step();
        n_cmp++; if (bus.instr !== 16'h8003 || bus.pc_inc !== 16'h0008) begin n_fail++; $display("FAIL stall_skid got %h/%h want 8003/0008", bus.instr, bus.pc_inc); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0008) begin n_fail++; $display("FAIL stall_resume got %b/%h want 1/0008", bus.imem_req, bus.imem_addr); end
        step();
        n_cmp++; if (bus.instr !== 16'h8004 || bus.pc_inc !== 16'h000A) begin n_fail++; $display("FAIL stall_next got %h/%h want 8004/000a", bus.instr, bus.pc_inc); end
    endtask

    task automatic test_redirect_drain();
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0010;
        step();
        bus.redirect = 1'b0; lat = 3;
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0010) begin n_fail++; $display("FAIL redir_ack_same got %b/%h want 0/0010", bus.instr_valid, bus.imem_addr); end
        repeat (2) step();
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
        step();
        bus.redirect = 1'b0; lat = 0;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0010 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_hold got %b/%h/%b want 1/0010/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
        step();
        n_cmp++; if (bus.imem_addr !== 16'h0040 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_done got %h/%b want 0040/0", bus.imem_addr, bus.instr_valid); end
        step();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA040 || bus.pc_inc !== 16'h0042) begin n_fail++; $display("FAIL drain_target got %b/%h/%h want 1/a040/0042", bus.instr_valid, bus.instr, bus.pc_inc); end
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
        step();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr got %h want fffe", bus.imem_addr); end
        step();
        n_cmp++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_next got %h want 0000", bus.imem_addr); end
        n_cmp++; if (bus.instr !== 16'hB0FE || bus.pc_inc !== 16'h0000) begin n_fail++; $display("FAIL wrap_instr got %h/%h want b0fe/0000", bus.instr, bus.pc_inc); end
        step();
        n_cmp++; if (bus.instr !== 16'hC001 || bus.pc_inc !== 16'h0002) begin n_fail++; $display("FAIL wrap_after got %h/%h want c001/0002", bus.instr, bus.pc_inc); end
    endtask

    task automatic test_halt();
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0080;
        step();
        bus.redirect = 1'b0; bus.stall = 1'b1;
        step();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0000 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter got %b/%h/%b want 1/0000/1", bus.instr_valid, bus.instr, bus.halted); end
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_idle%0d got req %b halted %b want 0/1", c, bus.imem_req, bus.halted); end
            step();
        end
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0100; bus.stall = 1'b0;
        step();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.halted !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_exit got %b/%b want 0/0", bus.halted, bus.instr_valid); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin n_fail++; $display("FAIL halt_refetch got %b/%h want 1/0100", bus.imem_req, bus.imem_addr); end
        step();
        n_cmp++; if (bus.instr !== 16'h8080 || bus.pc_inc !== 16'h0102) begin n_fail++; $display("FAIL halt_resume got %h/%h want 8080/0102", bus.instr, bus.pc_inc); end
    endtask

    task automatic test_misaligned_reset();
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0023;
        step();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.err !== 1'b1 || bus.imem_addr !== 16'h0022) begin n_fail++; $display("FAIL misal_redir got %b/%h want 1/0022", bus.err, bus.imem_addr); end
        step();
        n_cmp++; if (bus.instr !== 16'h8011 || bus.pc_inc !== 16'h0024) begin n_fail++; $display("FAIL misal_fetch got %h/%h want 8011/0024", bus.instr, bus.pc_inc); end
        lat = 5;
        repeat (2) step();
        n_cmp++; if (bus.err !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0024) begin n_fail++; $display("FAIL misal_sticky got %b/%b/%h want 1/1/0024", bus.err, bus.imem_req, bus.imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0000 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_bus got %b/%h/%b want 0/0000/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
        n_cmp++; if (bus.instr !== 16'h0800 || bus.pc_inc !== 16'h0000 || bus.err !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL async_rst_slot got %h/%h/%b/%b want 0800/0000/0/0", bus.instr, bus.pc_inc, bus.err, bus.halted); end
        lat = 0;
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_restart got %b/%h want 1/0000", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h8000 | 16'(i);
        mem[16'h0000] = 16'hC001;
        mem[16'h0001] = 16'hC102;
        mem[16'h0002] = 16'hC203;
        mem[16'h0020] = 16'hA040;
        mem[16'h0040] = 16'h0000;
        mem[16'h7FFF] = 16'hB0FE;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_wrap();
        test_halt();
        test_misaligned_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
